// File: rtl/ntt_pe_operand_sequencer_if.sv
// Bundle between a transform controller and the NTT PE operand sequencer:
// start/inverse request in, PE operation fields and write-back strobe out.
interface ntt_pe_operand_sequencer_if #(
   parameter int LOGL = 3
);
   logic            start;
   logic            inv_in;
   logic            busy;
   logic            done;
   logic            op_valid;
   logic [LOGL-1:0] a_addr;
   logic [LOGL-1:0] b_addr;
   logic [LOGL-2:0] tf_addr;
   logic            sub;
   logic            inv;
   logic            wr_en;
   logic [LOGL-1:0] wr_addr;

   modport master (
      output start, inv_in,
      input  busy, done, op_valid, a_addr, b_addr, tf_addr, sub, inv, wr_en, wr_addr
   );

   modport slave (
      input  start, inv_in,
      output busy, done, op_valid, a_addr, b_addr, tf_addr, sub, inv, wr_en, wr_addr
   );
endinterface

// File: rtl/ntt_pe_operand_sequencer.sv
// Walks an in-place radix-2 NTT/INTT, issuing each butterfly as two PE ops
// (sub=0 then sub=1) and the matching write-back strobe PIPE_LAT cycles later.
module ntt_pe_operand_sequencer #(
   parameter int LOGL     = 3,
   parameter int PIPE_LAT = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   ntt_pe_operand_sequencer_if.slave bus
);
   localparam int W   = LOGL + 1;
   localparam int TFW = LOGL - 1;
   localparam int SW  = $clog2(LOGL + 1);
   localparam int DW  = $clog2(PIPE_LAT + 1);
   localparam logic [W-1:0]  L_PTS      = W'(1) << LOGL;
   localparam logic [SW-1:0] LAST_S     = SW'(LOGL - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          r_state;
   logic [SW-1:0]   r_s;
   logic [W-1:0]    r_g;
   logic [W-1:0]    r_k;
   logic            r_ph;
   logic [DW-1:0]   r_drainCnt;
   logic            r_inv;
   logic            r_busy;
   logic            r_done;
   logic            r_opValid;
   logic            r_sub;
   logic [LOGL-1:0] r_aAddr;
   logic [LOGL-1:0] r_bAddr;
   logic [TFW-1:0]  r_tfAddr;
   logic [PIPE_LAT-1:0] r_pipeV;
   logic [LOGL-1:0]     r_pipeA [PIPE_LAT];

   logic [W-1:0]    w_len;
   logic [W-1:0]    w_gEnd;
   logic [W-1:0]    w_nG;
   logic [W-1:0]    w_nK;
   logic            w_nPh;
   logic            w_stageEnd;

   // Advance (g, k, ph) within a stage; the stage ends when g steps past L.
   always_comb begin
      w_len      = W'(1) << r_s;
      w_gEnd     = r_g + (w_len << 1);
      w_nG       = r_g;
      w_nK       = r_k;
      w_nPh      = ~r_ph;
      w_stageEnd = 1'b0;
      if (r_ph) begin
         if (r_k + W'(1) == w_len) begin
            w_nK       = '0;
            w_nG       = w_gEnd;
            w_stageEnd = (w_gEnd >= L_PTS);
         end else begin
            w_nK = r_k + W'(1);
         end
      end
   end

   logic [SW-1:0]   w_selS;
   logic [W-1:0]    w_selG;
   logic [W-1:0]    w_selK;
   logic            w_selPh;
   logic [W-1:0]    w_selLen;
   logic [LOGL-1:0] w_aNext;
   logic [LOGL-1:0] w_bNext;
   logic [TFW-1:0]  w_tfNext;
   logic            w_loadOp;

   // Counters of the op that will be shown next cycle: a fresh stage starts
   // at g=k=ph=0, otherwise the in-stage successor.
   always_comb begin
      w_selS  = r_s;
      w_selG  = w_nG;
      w_selK  = w_nK;
      w_selPh = w_nPh;
      if (r_state != RUN) begin
         w_selS  = (r_state == DRAIN) ? r_s + SW'(1) : '0;
         w_selG  = '0;
         w_selK  = '0;
         w_selPh = 1'b0;
      end
      w_selLen = W'(1) << w_selS;
      w_aNext  = LOGL'(w_selG + w_selK);
      w_bNext  = LOGL'(w_selG + w_selK + w_selLen);
      w_tfNext = TFW'(w_selK << (LAST_S - w_selS));
      w_loadOp = ((r_state == IDLE) && bus.start) ||
                 ((r_state == RUN) && !w_stageEnd) ||
                 ((r_state == DRAIN) && (r_drainCnt == DRAIN_LAST) && (r_s < LAST_S));
   end

   // Single FSM with registered outputs; the write-back delay line shifts every
   // cycle so ops issued at the end of a stage still reach the RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_s        <= '0;
         r_g        <= '0;
         r_k        <= '0;
         r_ph       <= 1'b0;
         r_drainCnt <= '0;
         r_inv      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_opValid  <= 1'b0;
         r_sub      <= 1'b0;
         r_aAddr    <= '0;
         r_bAddr    <= '0;
         r_tfAddr   <= '0;
         r_pipeV    <= '0;
         for (int i = 0; i < PIPE_LAT; i++) r_pipeA[i] <= '0;
      end else begin
         r_pipeV    <= {r_pipeV[PIPE_LAT-2:0], r_opValid};
         r_pipeA[0] <= r_sub ? r_bAddr : r_aAddr;
         for (int i = 1; i < PIPE_LAT; i++) r_pipeA[i] <= r_pipeA[i-1];
         r_done <= 1'b0;

         if (w_loadOp) begin
            r_opValid <= 1'b1;
            r_aAddr   <= w_aNext;
            r_bAddr   <= w_bNext;
            r_tfAddr  <= w_tfNext;
            r_sub     <= w_selPh;
         end else begin
            r_opValid <= 1'b0;
            r_aAddr   <= '0;
            r_bAddr   <= '0;
            r_tfAddr  <= '0;
            r_sub     <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_inv   <= bus.inv_in;
                  r_s     <= '0;
                  r_g     <= '0;
                  r_k     <= '0;
                  r_ph    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_stageEnd) begin
                  r_drainCnt <= '0;
                  r_state    <= DRAIN;
               end else begin
                  r_g  <= w_nG;
                  r_k  <= w_nK;
                  r_ph <= w_nPh;
               end
            end
            DRAIN: begin
               if (r_drainCnt == DRAIN_LAST) begin
                  if (r_s < LAST_S) begin
                     r_s     <= r_s + SW'(1);
                     r_g     <= '0;
                     r_k     <= '0;
                     r_ph    <= 1'b0;
                     r_state <= RUN;
                  end else begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end else begin
                  r_drainCnt <= r_drainCnt + DW'(1);
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.op_valid = r_opValid;
   assign bus.a_addr   = r_aAddr;
   assign bus.b_addr   = r_bAddr;
   assign bus.tf_addr  = r_tfAddr;
   assign bus.sub      = r_sub;
   assign bus.inv      = r_inv;
   assign bus.wr_en    = r_pipeV[PIPE_LAT-1];
   assign bus.wr_addr  = r_pipeA[PIPE_LAT-1];
endmodule
